ppu_vram_address_port: RTL

CPU-side front end for the PPU's VRAM access path: decodes CPU accesses to PPUCTRL ($2000), PPUSTATUS ($2002), PPUADDR ($2006) and PPUDATA ($2007), and maintains the 15-bit VRAM address (v) plus the temporary address (t). It drives the downstream VRAM setter/getter stage through an activation-trigger handshake, then auto-increments v by 1 or 32. It sits between the CPU register decode and the VRAM setter/getter.

---
 rtl/ppu_vram_address_port.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ppu_vram_address_port.sv
// ppu_vram_address_port
//   CPU-side front end of the PPU VRAM access path. Decodes CPU accesses to
//   PPUCTRL ($2000), PPUSTATUS ($2002), PPUADDR ($2006) and PPUDATA ($2007),
//   keeps the 15-bit VRAM address v and the temporary address t, drives the
//   downstream setter/getter through an activation-trigger handshake and then
//   auto-increments v by 1 or 32.
//
// Optional feature macro: PPU_PALETTE_BYPASS_EN
//   When defined, PPUDATA accesses with v >= 0x3F00 skip the handshake and go
//   straight to the increment cycle; writes pulse paletteWrite_OUT there.
//
// Handshake: a PPUDATA access raises activationTrigger_OUT for TRIG_CYCLES
//   cycles (setter latches rwSel_OUT on the rise, vramData_OUT on the fall),
//   then waits for operationDone_IN, or DONE_TIMEOUT cycles, before the
//   increment cycle. busy_OUT is high from the access until back in IDLE.
//
// Ports:
//   clock_IN, resetN_IN        clock, asynchronous active-low reset
//   cpuAccess_STB              one-cycle strobe per CPU register access
//   regSelect_IN[2:0]          register index (0, 2, 6, 7 decoded)
//   cpuRW_IN, cpuData_IN[7:0]  access direction (1=read) and write data
//   operationDone_IN           completion from the setter/getter
//   address_OUT[14:0]          current v
//   vramData_OUT[7:0]          latched PPUDATA write byte
//   rwSel_OUT                  1=read, 0=write
//   activationTrigger_OUT      handshake trigger
//   busy_OUT                   state != IDLE
//   overrun_OUT                sticky: PPUDATA access dropped while busy
//   paletteWrite_OUT           one-cycle palette write strobe
//   dbgState_OUT[1:0]          FSM state (0 IDLE, 1 TRIG, 2 WAIT, 3 INC)
module ppu_vram_address_port #(
    parameter int TRIG_CYCLES  = 4,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic        clock_IN,
    input  logic        resetN_IN,
    input  logic        cpuAccess_STB,
    input  logic [2:0]  regSelect_IN,
    input  logic        cpuRW_IN,
    input  logic [7:0]  cpuData_IN,
    input  logic        operationDone_IN,
    output logic [14:0] address_OUT,
    output logic [7:0]  vramData_OUT,
    output logic        rwSel_OUT,
    output logic        activationTrigger_OUT,
    output logic        busy_OUT,
    output logic        overrun_OUT,
    output logic        paletteWrite_OUT,
    output logic [1:0]  dbgState_OUT
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRIG = 2'd1, S_WAIT = 2'd2, S_INC = 2'd3} state_t;

    localparam int CMAX = (DONE_TIMEOUT > TRIG_CYCLES) ? DONE_TIMEOUT : TRIG_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [14:0]   v_q, v_d, t_q, t_d;
    logic          w_q, w_d, inc32_q, inc32_d;
    logic [7:0]    data_q, data_d;
    logic          rw_q, rw_d, trig_q, trig_d, ovr_q, ovr_d, pend_q, pend_d;
`ifdef PPU_PALETTE_BYPASS_EN
    logic          bypass_q, bypass_d;
`endif

    logic wr_ctrl, rd_status, wr_addr, acc_data;

    assign wr_ctrl   = cpuAccess_STB && (regSelect_IN == 3'd0) && !cpuRW_IN;
    assign rd_status = cpuAccess_STB && (regSelect_IN == 3'd2) &&  cpuRW_IN;
    assign wr_addr   = cpuAccess_STB && (regSelect_IN == 3'd6) && !cpuRW_IN;
    assign acc_data  = cpuAccess_STB && (regSelect_IN == 3'd7);

    always_ff @(posedge clock_IN or negedge resetN_IN) begin
        if (!resetN_IN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            v_q     <= '0;
            t_q     <= '0;
            w_q     <= 1'b0;
            inc32_q <= 1'b0;
            data_q  <= '0;
            rw_q    <= 1'b1;
            trig_q  <= 1'b0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
`ifdef PPU_PALETTE_BYPASS_EN
            bypass_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            t_q     <= t_d;
            w_q     <= w_d;
            inc32_q <= inc32_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            trig_q  <= trig_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
`ifdef PPU_PALETTE_BYPASS_EN
            bypass_q <= bypass_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        t_d     = t_q;
        w_d     = w_q;
        inc32_d = inc32_q;
        data_d  = data_q;
        rw_d    = rw_q;
        trig_d  = trig_q;
        ovr_d   = ovr_q;
        pend_d  = pend_q;
`ifdef PPU_PALETTE_BYPASS_EN
        bypass_d = bypass_q;
`endif

        // Register-side effects that do not depend on the FSM.
        if (wr_ctrl)   inc32_d = cpuData_IN[2];
        if (rd_status) w_d = 1'b0;
        if (wr_addr) begin
            if (!w_q) begin
                t_d = {1'b0, cpuData_IN[5:0], t_q[7:0]};
                w_d = 1'b1;
            end else begin
                t_d = {t_q[14:8], cpuData_IN};
                w_d = 1'b0;
                // v follows t immediately when idle; otherwise the load is
                // deferred to the increment cycle so address_OUT stays stable.
                if (state_q == S_IDLE) v_d = t_d;
                else                   pend_d = 1'b1;
            end
        end
        if (acc_data && (state_q != S_IDLE)) ovr_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (acc_data) begin
                    rw_d = cpuRW_IN;
                    if (!cpuRW_IN) data_d = cpuData_IN;
`ifdef PPU_PALETTE_BYPASS_EN
                    if (v_q >= 15'h3F00) begin
                        state_d  = S_INC;
                        bypass_d = 1'b1;
                    end else
`endif
                    begin
                        state_d = S_TRIG;
                        trig_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            S_TRIG: begin
                if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
                    state_d = S_WAIT;
                    trig_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (operationDone_IN || (cnt_q == CW'(DONE_TIMEOUT - 1))) begin
                    state_d = S_INC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_INC: begin
                // A second $2006 write landing in this very cycle must not be
                // lost: it replaces the increment just like a pending load.
                if (wr_addr && w_q) v_d = t_d;
                else if (pend_q)    v_d = t_q;
                else                v_d = v_q + (inc32_q ? 15'd32 : 15'd1);
                pend_d  = 1'b0;
                rw_d    = 1'b1;
                state_d = S_IDLE;
`ifdef PPU_PALETTE_BYPASS_EN
                bypass_d = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign address_OUT           = v_q;
    assign vramData_OUT          = data_q;
    assign rwSel_OUT             = rw_q;
    assign activationTrigger_OUT = trig_q;
    assign busy_OUT              = (state_q != S_IDLE);
    assign overrun_OUT           = ovr_q;
    assign dbgState_OUT          = state_q;
`ifdef PPU_PALETTE_BYPASS_EN
    assign paletteWrite_OUT      = (state_q == S_INC) && bypass_q && !rw_q;
`else
    assign paletteWrite_OUT      = 1'b0;
`endif

endmodule
